// File: rtl/rocket_controller.sv
// -----------------------------------------------------------------------------
// rocket_controller
//
// Launches and steers the single tank rocket. A rising edge on the fire key
// while the rocket is idle spawns the rocket centred on the tank. The rocket
// then travels one step per video frame in the direction the tank faced at
// launch. The flight ends when the rocket hits something or would leave the
// screen. A cooldown of a fixed number of frames must then pass before the
// next launch is accepted.
//
// Parameters
//   SPEED           pixels advanced per frame
//   COOLDOWN_FRAMES frames after termination before a new launch is accepted
//   TANK_SIZE       tank sprite edge in pixels (rocket sprite edge is 8)
//   X_MAX, Y_MAX    largest legal rocket top-left coordinate
//
// Ports
//   clk             system clock, all state on its rising edge
//   resetN          asynchronous active-low reset
//   startOfFrame    one-cycle pulse per video frame
//   fire            fire key level, synchronous to clk
//   tank_x, tank_y  tank top-left position
//   tank_direction  0 up, 1 right, 2 down, 3 left
//   collision       rocket pixel drawn over a wall/tank this cycle
//   rocket_x/_y     rocket top-left position (registered)
//   last_direction  direction latched at launch (registered)
//   rocket_enable   rocket visible and live (registered)
//   shots_fired     count of accepted launches, wraps at 256 (registered)
// -----------------------------------------------------------------------------
module rocket_controller #(
    parameter int SPEED           = 4,
    parameter int COOLDOWN_FRAMES = 16,
    parameter int TANK_SIZE       = 32,
    parameter int X_MAX           = 632,
    parameter int Y_MAX           = 472
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        fire,
    input  logic [10:0] tank_x,
    input  logic [10:0] tank_y,
    input  logic [1:0]  tank_direction,
    input  logic        collision,
    output logic [10:0] rocket_x,
    output logic [10:0] rocket_y,
    output logic [1:0]  last_direction,
    output logic        rocket_enable,
    output logic [7:0]  shots_fired
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    // Rocket sprite is 8x8, so centring it on the tank offsets by half the
    // tank edge minus half the rocket edge.
    localparam logic [10:0] OFFSET = 11'(TANK_SIZE / 2 - 4);
    localparam logic [10:0] STEP   = 11'(SPEED);
    localparam logic [10:0] X_LIM  = 11'(X_MAX - SPEED);
    localparam logic [10:0] Y_LIM  = 11'(Y_MAX - SPEED);
    localparam logic [7:0]  CD_LOAD = 8'(COOLDOWN_FRAMES);

    state_t      state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [1:0]  dir_q, dir_d;
    logic        en_q, en_d;
    logic [7:0]  shots_q, shots_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fire_q;

    logic        launch;
    logic        at_edge;
    logic [10:0] step_x;
    logic [10:0] step_y;

    // Only a 0->1 transition of the key launches; holding the key does not
    // auto-repeat.
    assign launch = fire & ~fire_q;

    // Candidate position one step ahead, plus whether that step would leave
    // the legal area. The edge tests are done on the current position so no
    // underflow/overflow of the 11-bit coordinate is ever stored.
    always_comb begin
        step_x  = x_q;
        step_y  = y_q;
        at_edge = 1'b0;
        unique case (dir_q)
            2'd0: begin
                at_edge = (y_q < STEP);
                step_y  = y_q - STEP;
            end
            2'd1: begin
                at_edge = (x_q > X_LIM);
                step_x  = x_q + STEP;
            end
            2'd2: begin
                at_edge = (y_q > Y_LIM);
                step_y  = y_q + STEP;
            end
            default: begin
                at_edge = (x_q < STEP);
                step_x  = x_q - STEP;
            end
        endcase
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        en_d    = en_q;
        shots_d = shots_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = FLY;
                    en_d    = 1'b1;
                    dir_d   = tank_direction;
                    x_d     = tank_x + OFFSET;
                    y_d     = tank_y + OFFSET;
                    shots_d = shots_q + 8'd1;
                end
            end

            FLY: begin
                // A hit ends the flight before any frame move is applied.
                if (collision || (startOfFrame && at_edge)) begin
                    state_d = COOLDOWN;
                    en_d    = 1'b0;
                    cnt_d   = CD_LOAD;
                end else if (startOfFrame) begin
                    x_d = step_x;
                    y_d = step_y;
                end
            end

            COOLDOWN: begin
                // A zero count (including COOLDOWN_FRAMES=0) leaves at once.
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else if (startOfFrame) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            x_q     <= 11'd0;
            y_q     <= 11'd0;
            dir_q   <= 2'd0;
            en_q    <= 1'b0;
            shots_q <= 8'd0;
            cnt_q   <= 8'd0;
            // Reset to 1 so a key held through reset is not seen as an edge.
            fire_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            shots_q <= shots_d;
            cnt_q   <= cnt_d;
            fire_q  <= fire;
        end
    end

    assign rocket_x       = x_q;
    assign rocket_y       = y_q;
    assign last_direction = dir_q;
    assign rocket_enable  = en_q;
    assign shots_fired    = shots_q;

endmodule
